// File: rtl/spi_segment_sequencer_if.sv
// Table, engine handshake and SPI bus signals of the segment sequencer.
// The sequencer drives the master modport; the table and engines sit on the slave side.
interface spi_segment_sequencer_if #(
    parameter int COORD_W = 9,
    parameter int IDX_W   = 4
);
    logic [IDX_W-1:0]     o_seg_addr;
    logic [4*COORD_W-1:0] i_seg_data;
    logic [COORD_W-1:0]   o_x1, o_y1, o_x2, o_y2;
    logic                 o_vert_start, o_line_start, o_line2_start;
    logic                 i_vert_done, i_line_done, i_line2_done;
    logic                 i_vert_mosi, i_vert_dc, i_vert_cs;
    logic                 i_line_mosi, i_line_dc, i_line_cs;
    logic                 i_line2_mosi, i_line2_dc, i_line2_cs;
    logic                 o_mosi, o_dc, o_cs;

    modport master (
        output o_seg_addr, o_x1, o_y1, o_x2, o_y2,
        output o_vert_start, o_line_start, o_line2_start,
        output o_mosi, o_dc, o_cs,
        input  i_seg_data, i_vert_done, i_line_done, i_line2_done,
        input  i_vert_mosi, i_vert_dc, i_vert_cs,
        input  i_line_mosi, i_line_dc, i_line_cs,
        input  i_line2_mosi, i_line2_dc, i_line2_cs
    );

    modport slave (
        input  o_seg_addr, o_x1, o_y1, o_x2, o_y2,
        input  o_vert_start, o_line_start, o_line2_start,
        input  o_mosi, o_dc, o_cs,
        output i_seg_data, i_vert_done, i_line_done, i_line2_done,
        output i_vert_mosi, i_vert_dc, i_vert_cs,
        output i_line_mosi, i_line_dc, i_line_cs,
        output i_line2_mosi, i_line2_dc, i_line2_cs
    );
endinterface

// File: rtl/spi_segment_sequencer.sv
// Draw-list sequencer: fetches segments, classifies/normalises them, dispatches
// each to the vertical/line/line2 engine and muxes that engine onto the SPI bus.
module spi_segment_sequencer #(
    parameter int COORD_W = 9,
    parameter int MAX_SEG = 16,
    parameter int IDX_W   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [IDX_W:0]       i_seg_count,
    input  logic                 i_loop,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic [IDX_W-1:0]     o_seg_idx,
    output logic                 o_done,
    output logic                 o_aborted,
    spi_segment_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, WAIT} state_t;
    typedef enum logic [1:0] {SEL_VERT, SEL_LINE, SEL_LINE2} sel_t;

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_SEG);

    state_t             state, state_nxt;
    sel_t               sel, nsel;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     count, start_count, idx_inc;
    logic               loop_r, abort_pending, abort_now, sel_done, last_seg;
    logic               vert_start, line_start, line2_start;
    logic [COORD_W-1:0] sx1, sy1, sx2, sy2;
    logic [COORD_W-1:0] nx1, ny1, nx2, ny2;
    logic [COORD_W-1:0] x1, y1, x2, y2;

    assign start_count = (i_seg_count > MAX_CNT) ? MAX_CNT : i_seg_count;
    assign idx_inc     = {1'b0, idx} + (IDX_W+1)'(1);
    assign last_seg    = (idx_inc >= count);
    // A done coinciding with a fresh abort request still ends the run as aborted.
    assign abort_now   = abort_pending | i_abort;

    assign {sx1, sy1, sx2, sy2} = bus.i_seg_data;

    always_comb begin
        nx1  = sx1;
        ny1  = sy1;
        nx2  = sx2;
        ny2  = sy2;
        nsel = SEL_LINE;
        if (sx1 == sx2) begin
            nsel = SEL_VERT;
            if (sy1 > sy2) begin
                ny1 = sy2;
                ny2 = sy1;
            end
        end else begin
            if (sx1 > sx2) begin
                nx1 = sx2;
                ny1 = sy2;
                nx2 = sx1;
                ny2 = sy1;
            end
            nsel = (ny2 >= ny1) ? SEL_LINE : SEL_LINE2;
        end
    end

    always_comb begin
        unique case (sel)
            SEL_VERT:  sel_done = bus.i_vert_done;
            SEL_LINE:  sel_done = bus.i_line_done;
            SEL_LINE2: sel_done = bus.i_line2_done;
            default:   sel_done = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_start && start_count != '0) state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE:  state_nxt = WAIT;
            WAIT: begin
                if (sel_done) begin
                    if (abort_now)              state_nxt = IDLE;
                    else if (!last_seg || loop_r) state_nxt = FETCH;
                    else                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state != IDLE);
        bus.o_mosi = 1'b0;
        bus.o_dc   = 1'b0;
        bus.o_cs   = 1'b1;
        if (state == WAIT) begin
            unique case (sel)
                SEL_VERT:  {bus.o_mosi, bus.o_dc, bus.o_cs} = {bus.i_vert_mosi, bus.i_vert_dc, bus.i_vert_cs};
                SEL_LINE:  {bus.o_mosi, bus.o_dc, bus.o_cs} = {bus.i_line_mosi, bus.i_line_dc, bus.i_line_cs};
                SEL_LINE2: {bus.o_mosi, bus.o_dc, bus.o_cs} = {bus.i_line2_mosi, bus.i_line2_dc, bus.i_line2_cs};
                default:   {bus.o_mosi, bus.o_dc, bus.o_cs} = 3'b001;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx           <= '0;
            count         <= '0;
            loop_r        <= 1'b0;
            abort_pending <= 1'b0;
            sel           <= SEL_VERT;
            {x1, y1, x2, y2} <= '0;
            vert_start    <= 1'b0;
            line_start    <= 1'b0;
            line2_start   <= 1'b0;
            o_done        <= 1'b0;
            o_aborted     <= 1'b0;
        end else begin
            vert_start  <= 1'b0;
            line_start  <= 1'b0;
            line2_start <= 1'b0;
            o_done      <= 1'b0;
            o_aborted   <= 1'b0;
            if (state != IDLE && i_abort) abort_pending <= 1'b1;
            unique case (state)
                IDLE: begin
                    idx           <= '0;
                    abort_pending <= 1'b0;
                    if (i_start) begin
                        count  <= start_count;
                        loop_r <= i_loop;
                        o_done <= (start_count == '0);
                    end
                end
                FETCH: ;
                DECODE: begin
                    {x1, y1, x2, y2} <= {nx1, ny1, nx2, ny2};
                    sel         <= nsel;
                    vert_start  <= (nsel == SEL_VERT);
                    line_start  <= (nsel == SEL_LINE);
                    line2_start <= (nsel == SEL_LINE2);
                end
                WAIT: begin
                    if (sel_done) begin
                        if (abort_now) begin
                            o_aborted <= 1'b1;
                            idx       <= '0;
                        end else if (!last_seg) begin
                            idx <= idx_inc[IDX_W-1:0];
                        end else if (loop_r) begin
                            idx <= '0;
                        end else begin
                            o_done <= 1'b1;
                            idx    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_seg_addr    = idx;
    assign o_seg_idx         = idx;
    assign bus.o_x1          = x1;
    assign bus.o_y1          = y1;
    assign bus.o_x2          = x2;
    assign bus.o_y2          = y2;
    assign bus.o_vert_start  = vert_start;
    assign bus.o_line_start  = line_start;
    assign bus.o_line2_start = line2_start;
endmodule

// File: tb/tb_spi_segment_sequencer.sv
// Bench for spi_segment_sequencer: table RAM and engine models drive the DUT; a
// classification model built from the segment rules predicts every dispatch.
`timescale 1ns/1ps
module tb_spi_segment_sequencer;
    localparam int CW = 9;
    localparam int MS = 16;
    localparam int IW = 4;

    typedef struct {
        int kind;
        int x1, y1, x2, y2;
        int idx;
        int cyc;
    } ev_t;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start, i_loop, abort_tb;
    logic          abort_eng = 1'b0;
    logic          i_abort;
    logic [IW:0]   i_seg_count;
    logic          o_busy, o_done, o_aborted;
    logic [IW-1:0] o_seg_idx;
    logic [2:0]    mdone = '0;
    logic [2:0]    sdone = '0;
    logic [8:0]    espi  = '0;
    logic [4*CW-1:0] tbl [MS];

    int  total = 0, bad = 0, cyc = 0;
    int  cnt = 0, act = -1, eng_delay = 10;
    bit  spur_en = 0, abort_on_done = 0;
    int  n_done, n_ab, end_cyc;
    logic busy_end;
    ev_t log_q[$];

    spi_segment_sequencer_if #(.COORD_W(CW), .IDX_W(IW)) bus ();

    spi_segment_sequencer #(.COORD_W(CW), .MAX_SEG(MS), .IDX_W(IW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_seg_count(i_seg_count),
        .i_loop(i_loop), .i_abort(i_abort), .o_busy(o_busy), .o_seg_idx(o_seg_idx),
        .o_done(o_done), .o_aborted(o_aborted), .bus(bus)
    );

    initial forever #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;
    always @(posedge i_clk) bus.i_seg_data <= tbl[bus.o_seg_addr];

    assign i_abort          = abort_tb | abort_eng;
    assign bus.i_vert_done  = mdone[0] | sdone[0];
    assign bus.i_line_done  = mdone[1] | sdone[1];
    assign bus.i_line2_done = mdone[2] | sdone[2];
    assign {bus.i_vert_cs,  bus.i_vert_dc,  bus.i_vert_mosi}  = espi[2:0];
    assign {bus.i_line_cs,  bus.i_line_dc,  bus.i_line_mosi}  = espi[5:3];
    assign {bus.i_line2_cs, bus.i_line2_dc, bus.i_line2_mosi} = espi[8:6];

    // Engines: done pulse eng_delay cycles after their start; act names the engine owning the bus.
    always @(negedge i_clk) begin
        espi  = 9'($urandom);
        sdone = '0;
        if (i_rst) begin
            mdone = '0; abort_eng = 1'b0; cnt = 0; act = -1;
        end else begin
            if (mdone != '0) begin
                mdone = '0; abort_eng = 1'b0; act = -1;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mdone[act] = 1'b1;
                    if (abort_on_done) abort_eng = 1'b1;
                end else if (spur_en && cnt == eng_delay / 2) begin
                    sdone = 3'b111 ^ (3'b001 << act);
                end
            end
            if (bus.o_vert_start | bus.o_line_start | bus.o_line2_start) begin
                act = bus.o_vert_start ? 0 : (bus.o_line_start ? 1 : 2);
                cnt = eng_delay;
            end
        end
    end

    function automatic logic [4*CW-1:0] mk(input int a, input int b, input int c, input int d);
        return {CW'(a), CW'(b), CW'(c), CW'(d)};
    endfunction

    function automatic ev_t classify(input logic [4*CW-1:0] s);
        ev_t e;
        int a, b, c, d;
        a = int'(s[4*CW-1:3*CW]); b = int'(s[3*CW-1:2*CW]);
        c = int'(s[2*CW-1:CW]);   d = int'(s[CW-1:0]);
        e.idx = 0; e.cyc = 0;
        if (a == c) begin
            e.kind = 0; e.x1 = a; e.x2 = a;
            e.y1 = (b < d) ? b : d;
            e.y2 = (b < d) ? d : b;
        end else begin
            if (a > c) begin e.x1 = c; e.y1 = d; e.x2 = a; e.y2 = b; end
            else       begin e.x1 = a; e.y1 = b; e.x2 = c; e.y2 = d; end
            e.kind = (e.y2 >= e.y1) ? 1 : 2;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        ev_t e;
        logic [2:0] exp3;
        @(negedge i_clk); #1;
        case (act)
            0:       exp3 = espi[2:0];
            1:       exp3 = espi[5:3];
            2:       exp3 = espi[8:6];
            default: exp3 = 3'b100;
        endcase
        chk($sformatf("spi_mux@%0d", cyc), {bus.o_cs, bus.o_dc, bus.o_mosi}, exp3);
        if (bus.o_vert_start | bus.o_line_start | bus.o_line2_start) begin
            e.kind = (32'(bus.o_vert_start) + 32'(bus.o_line_start) + 32'(bus.o_line2_start) != 1) ? 3 :
                     (bus.o_vert_start ? 0 : (bus.o_line_start ? 1 : 2));
            e.x1 = int'(bus.o_x1); e.y1 = int'(bus.o_y1);
            e.x2 = int'(bus.o_x2); e.y2 = int'(bus.o_y2);
            e.idx = int'(o_seg_idx); e.cyc = cyc;
            log_q.push_back(e);
        end
        if (o_done)    begin n_done++; end_cyc = cyc; busy_end = o_busy; end
        if (o_aborted) begin n_ab++;   end_cyc = cyc; busy_end = o_busy; end
    endtask

    task automatic run(input string nm, input int cnt_in, input bit loop_in, input int abort_at,
                       input bit poke, input int n_exp, input bit exp_abort);
        int s, eff, k;
        bit abort_sent;
        ev_t e;
        log_q.delete(); n_done = 0; n_ab = 0; busy_end = 1'b1; end_cyc = -1; abort_sent = 0;
        eff = (cnt_in > MS) ? MS : cnt_in;
        i_seg_count = (IW+1)'(cnt_in); i_loop = loop_in; i_start = 1'b1;
        s = cyc;
        step();
        i_start = 1'b0; i_loop = ~loop_in; i_seg_count = (IW+1)'($urandom);
        chk({nm, " addr_s1"}, bus.o_seg_addr, 0);
        k = 0;
        while (n_done == 0 && n_ab == 0 && k < 3000) begin
            if (abort_at > 0 && log_q.size() == abort_at && !abort_sent) begin
                abort_tb = 1'b1; abort_sent = 1;
            end
            if (poke && k == 6) i_start = 1'b1;
            step();
            abort_tb = 1'b0; i_start = 1'b0; k++;
        end
        chk({nm, " finished_in_budget"}, (n_done + n_ab != 0), 1);
        repeat (4) step();
        chk({nm, " nstarts"}, log_q.size(), n_exp);
        for (int i = 0; i < log_q.size() && i < n_exp; i++) begin
            e = classify(tbl[i % eff]);
            chk($sformatf("%s kind[%0d]", nm, i), log_q[i].kind, e.kind);
            chk($sformatf("%s coords[%0d]", nm, i),
                {log_q[i].x1[15:0], log_q[i].y1[15:0], log_q[i].x2[15:0], log_q[i].y2[15:0]},
                {e.x1[15:0], e.y1[15:0], e.x2[15:0], e.y2[15:0]});
            chk($sformatf("%s idx[%0d]", nm, i), log_q[i].idx, i % eff);
            chk($sformatf("%s start_cyc[%0d]", nm, i), log_q[i].cyc,
                (i == 0) ? s + 3 : log_q[i-1].cyc + eng_delay + 3);
        end
        if (n_exp == 0) chk({nm, " end_cyc"}, end_cyc, s + 1);
        else if (log_q.size() > 0) chk({nm, " end_cyc"}, end_cyc, log_q[log_q.size()-1].cyc + eng_delay + 1);
        chk({nm, " n_done"}, n_done, exp_abort ? 0 : 1);
        chk({nm, " n_aborted"}, n_ab, exp_abort ? 1 : 0);
        chk({nm, " busy_at_end"}, busy_end, 1'b0);
        chk({nm, " idle_busy"}, o_busy, 1'b0);
    endtask

    initial begin
        int k, c;
        logic [4*CW-1:0] r;
        i_rst = 1'b1; i_start = 1'b0; i_loop = 1'b0; abort_tb = 1'b0; i_seg_count = '0;
        for (int i = 0; i < MS; i++) tbl[i] = '0;
        n_done = 0; n_ab = 0; busy_end = 1'b0; end_cyc = 0;
        repeat (3) step();
        chk("rst busy", o_busy, 1'b0);
        chk("rst addr_idx", {bus.o_seg_addr, o_seg_idx}, '0);
        chk("rst coords", {bus.o_x1, bus.o_y1, bus.o_x2, bus.o_y2}, '0);
        chk("rst pulses", {bus.o_vert_start, bus.o_line_start, bus.o_line2_start, o_done, o_aborted}, '0);
        chk("rst spi", {bus.o_mosi, bus.o_dc, bus.o_cs}, 3'b001);
        i_rst = 1'b0;
        step();

        // Pentagon with a spurious done from idle engines and an i_start poke mid-run.
        tbl[0] = mk(120, 46, 225, 122); tbl[1] = mk(225, 122, 185, 245);
        tbl[2] = mk(185, 245, 55, 245); tbl[3] = mk(55, 245, 15, 122);
        tbl[4] = mk(15, 122, 120, 46);
        spur_en = 1;
        run("pentagon", 5, 0, 0, 1, 5, 0);
        spur_en = 0;
        if (log_q.size() == 5) begin
            chk("pent kinds", {log_q[0].kind[1:0], log_q[1].kind[1:0], log_q[2].kind[1:0],
                               log_q[3].kind[1:0], log_q[4].kind[1:0]}, {2'd1, 2'd2, 2'd1, 2'd1, 2'd2});
            chk("pent seg2 swap", {log_q[2].x1[15:0], log_q[2].y1[15:0], log_q[2].x2[15:0]},
                {16'd55, 16'd245, 16'd185});
        end

        // Explicit vertical and line2 normalisation.
        tbl[0] = mk(120, 90, 120, 46); tbl[1] = mk(225, 122, 185, 245);
        run("vert_line2", 2, 0, 0, 0, 2, 0);
        if (log_q.size() == 2) begin
            chk("vert kind_y", {log_q[0].kind[7:0], log_q[0].y1[15:0], log_q[0].y2[15:0]}, {8'd0, 16'd46, 16'd90});
            chk("line2 kind_xy", {log_q[1].kind[7:0], log_q[1].x1[15:0], log_q[1].y1[15:0]}, {8'd2, 16'd185, 16'd245});
        end

        run("count0", 0, 0, 0, 0, 0, 0);

        // Looping run aborted during index 1 of the second pass.
        tbl[0] = mk(120, 46, 225, 122); tbl[1] = mk(225, 122, 185, 245); tbl[2] = mk(77, 9, 77, 300);
        run("loop_abort", 3, 1, 5, 0, 5, 1);

        abort_on_done = 1;
        run("abort_with_done", 4, 0, 0, 0, 1, 1);
        abort_on_done = 0;

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < MS; i++) begin
                r = {CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom)};
                if (i % 4 == 1) r[2*CW-1:CW] = r[4*CW-1:3*CW];
                if (i % 7 == 3) r = {r[4*CW-1:2*CW], r[4*CW-1:2*CW]};
                tbl[i] = r;
            end
            c = $urandom_range(1, 20);
            eng_delay = $urandom_range(2, 12);
            run($sformatf("rand%0d", t), c, 0, 0, 0, (c > MS) ? MS : c, 0);
        end
        eng_delay = 10;

        // Asynchronous reset in WAIT, then a fresh run from address 0.
        log_q.delete();
        i_seg_count = 3; i_loop = 1'b1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        k = 0;
        while (log_q.size() < 2 && k < 100) begin step(); k++; end
        chk("rst_mid second_start_seen", log_q.size(), 2);
        step(); step();
        #2 i_rst = 1'b1;
        #1;
        chk("rst_mid cs", bus.o_cs, 1'b1);
        chk("rst_mid busy", o_busy, 1'b0);
        chk("rst_mid idx", o_seg_idx, '0);
        step(); step();
        i_rst = 1'b0;
        repeat (3) step();
        chk("rst_mid no_restart", log_q.size(), 2);
        run("after_rst", 2, 0, 0, 0, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_segment_sequencer.md
# spi_segment_sequencer

Parametrised draw-list sequencer for the SPI display path. It fetches line segments from a synchronous segment table and classifies each one as vertical, rising or falling. It normalises the endpoints, dispatches the segment to the matching drawing engine (vertical, line, line2) with a start/done handshake, and muxes that engine's SPI outputs onto the display bus. It replaces hard-wired per-figure connect blocks: any figure becomes a table plus a count, with optional looping and abort.

## Interface
Parameters:
- COORD_W, 9, coordinate width (x and y, unsigned)
- MAX_SEG, 16, maximum segments per run
- IDX_W, 4, segment index width; 2^IDX_W >= MAX_SEG

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- i_seg_count  in  IDX_W+1  number of segments; sampled with i_start
- i_loop  in  1  repeat table forever; sampled with i_start
- i_abort  in  1  request stop after the current segment
- o_seg_addr  out  IDX_W  table read address
- i_seg_data  in  4*COORD_W  {x1,y1,x2,y2}, x1 in MSBs; valid one cycle after o_seg_addr
- o_x1, o_y1, o_x2, o_y2  out  COORD_W each  normalised coordinates to engines
- o_vert_start, o_line_start, o_line2_start  out  1 each  one-cycle engine start pulses
- i_vert_done, i_line_done, i_line2_done  in  1 each  engine done pulses
- i_vert_mosi/dc/cs, i_line_mosi/dc/cs, i_line2_mosi/dc/cs  in  1 each  engine SPI outputs
- o_mosi, o_dc, o_cs  out  1 each  muxed SPI bus
- o_busy  out  1  high outside IDLE
- o_seg_idx  out  IDX_W  index of the segment in progress
- o_done  out  1  one-cycle pulse when a non-looping run completes
- o_aborted  out  1  one-cycle pulse when a run ends due to abort

## Operation
- States: IDLE, FETCH, DECODE, WAIT.
- IDLE:
  - o_seg_addr = 0 and idx = 0.
  - On i_start, latch count = min(i_seg_count, MAX_SEG) and latch loop.
  - If count == 0: o_done pulses next cycle and the block stays in IDLE. Otherwise go to FETCH.
- FETCH: o_seg_addr = idx. Go to DECODE.
- DECODE: sample i_seg_data, classify and normalise it into registered outputs, then go to WAIT with the selected start pulse high.
- Classification (unsigned compares):
  - x1 == x2 -> vertical. Output y1 = min, y2 = max, x = x1. A point (y1 == y2) is also vertical.
  - Otherwise swap endpoints if x1 > x2, so that o_x1 < o_x2.
    - o_y2 >= o_y1 -> line.
    - o_y2 < o_y1 -> line2.
- Engine select is held in a register (sel) from DECODE until the next DECODE.
- WAIT: only the done input of the selected engine is accepted; the others are ignored. On done:
  - If abort_pending: go to IDLE and pulse o_aborted.
  - Else if idx + 1 < count: increment idx and go to FETCH.
  - Else if loop: set idx = 0 and go to FETCH.
  - Else: go to IDLE and pulse o_done.
- i_abort is recorded as abort_pending whenever it is high in FETCH, DECODE or WAIT. Pending is cleared on return to IDLE. i_abort in IDLE has no effect. The running engine is never cut off mid-transfer.
- i_start outside IDLE is ignored.
- SPI mux:
  - In WAIT, o_mosi/o_dc/o_cs follow the selected engine combinationally.
  - Otherwise o_mosi = 0, o_dc = 0, o_cs = 1.

## Timing
- Reset values:
  - State IDLE; o_seg_addr, o_seg_idx and all coordinates 0.
  - All start pulses, o_done, o_aborted and o_busy at 0.
  - o_mosi = 0, o_dc = 0, o_cs = 1.
- Start latency: i_start at cycle s gives FETCH at s+1, DECODE at s+2, and the engine start pulse at s+3.
- Inter-segment gap: engine done at cycle d gives the next start pulse at d+3.
- o_done and o_aborted fire in the cycle after the final accepted done; o_busy falls in that same cycle.
- Start pulses are exactly one cycle wide. Coordinates are stable from the start pulse until the next DECODE.
- Done arriving together with i_abort in the same WAIT cycle counts as abort: the block ends in IDLE and pulses o_aborted.
- Reset mid-run returns to IDLE immediately and clears pending abort and loop.
- The engines are reset by the same i_rst.

## Test plan
- 5-segment pentagon table, count = 5, engines modelled with done after 10 cycles:
  - Exactly 5 starts occur, in the order vert/line/line2 as classified. (120,46)-(225,122) -> line; (185,245)-(55,245) swapped to (55,245)-(185,245) -> line.
  - o_done pulses once, 1 cycle after the 5th done.
- Segment (120,90)-(120,46) -> o_vert_start, with o_y1 = 46 and o_y2 = 90. Segment (225,122)-(185,245) -> line2, with endpoints swapped to o_x1 = 185, o_y1 = 245.
- count = 0 -> no start pulse, no address change, and o_done high at s+1.
- Loop with count = 3:
  - Addresses run 0,1,2,0,1.
  - i_abort asserted during segment index 1 of the 2nd pass -> that segment completes, o_aborted pulses, no o_done, o_busy = 0.
- Timing: start pulse at s+3, next start 3 cycles after done. In WAIT a spurious done from an unselected engine is ignored. i_start during WAIT is ignored.
- Async i_rst asserted in WAIT -> o_cs = 1 and o_busy = 0 immediately. A fresh i_start afterwards restarts from address 0.
